wb_pio_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares the single Wishbone slave port of the PIO block.
- Master 0 is the management SoC Wishbone (wbs_*); master 1 is a debug master driven from logic-analyzer bits.
- Grants are round-robin, with bus lock held while the owner keeps cyc asserted.
- A stalled-slave watchdog terminates hung cycles with a fixed read value.

---
 rtl/wb_pio_arbiter_if.sv | 18 +
 rtl/wb_pio_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_pio_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pio_arbiter_if.sv
// Wishbone link between one master and one slave.
interface wb_pio_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;  // master -> slave
  logic [DW-1:0] dat_r;  // slave -> master
  logic          ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_pio_arbiter.sv
// Two-master round-robin Wishbone arbiter with cyc lock and stalled-slave watchdog
// in front of the PIO slave port.
module wb_pio_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  wb_pio_arbiter_if.slave          m0,
  wb_pio_arbiter_if.slave          m1,
  wb_pio_arbiter_if.master         s,
  output logic [1:0]               gnt_o,
  output logic                     timeout_o,
  input  logic                     timeout_clr_i
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;

  logic            w_req0;
  logic            w_req1;
  logic            w_busy;
  logic            w_sel1;
  logic            w_own_cyc;
  logic            w_own_stb;
  logic            w_to;
  logic            w_s_stb;
  logic            w_ack;
  logic [DW-1:0]   w_dat;

  // State, last-grant, watchdog counter and sticky timeout flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Grant decision, watchdog and combinational datapath mux from the current owner.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_cnt_nxt     = '0;
    w_timeout_nxt = r_timeout & ~timeout_clr_i;

    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.adr   = '0;
    s.dat_w = '0;
    m0.ack   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.dat_r = '0;

    w_req0    = m0.cyc & m0.stb;
    w_req1    = m1.cyc & m1.stb;
    w_busy    = (r_state != IDLE);
    w_sel1    = (r_state == G1);
    w_own_cyc = w_sel1 ? m1.cyc : m0.cyc;
    w_own_stb = w_sel1 ? m1.stb : m0.stb;

    // Forced termination: owner still strobing, threshold reached and no real ack.
    w_to    = w_busy & w_own_cyc & w_own_stb & ~s.ack & (r_cnt == CW'(TIMEOUT - 1));
    w_s_stb = w_busy & w_own_stb & ~w_to;
    w_ack   = w_busy & (s.ack | w_to);
    w_dat   = w_to ? TIMEOUT_DATA : s.dat_r;

    if (w_busy) begin
      s.cyc   = w_own_cyc & ~w_to;
      s.stb   = w_s_stb;
      s.we    = w_sel1 ? m1.we    : m0.we;
      s.sel   = w_sel1 ? m1.sel   : m0.sel;
      s.adr   = w_sel1 ? m1.adr   : m0.adr;
      s.dat_w = w_sel1 ? m1.dat_w : m0.dat_w;
    end

    if (r_state == G0) begin
      m0.ack   = w_ack;
      m0.dat_r = w_dat;
    end
    if (r_state == G1) begin
      m1.ack   = w_ack;
      m1.dat_r = w_dat;
    end

    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_state_nxt = r_last ? G0 : G1;
        else if (w_req0)      w_state_nxt = G0;
        else if (w_req1)      w_state_nxt = G1;
      end
      G0, G1: begin
        if (w_to) begin
          w_state_nxt   = IDLE;
          w_last_nxt    = w_sel1;
          w_timeout_nxt = 1'b1;
        end else if (!w_own_cyc) begin
          // Release hands straight over to a waiting master, no idle bubble.
          w_last_nxt = w_sel1;
          if (w_sel1) w_state_nxt = w_req0 ? G0 : IDLE;
          else        w_state_nxt = w_req1 ? G1 : IDLE;
        end else if (w_s_stb && !s.ack) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign gnt_o     = r_state;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_pio_arbiter.sv
// Directed bench for wb_pio_arbiter: grant order, lock, watchdog and async reset.
module tb_wb_pio_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] gnt;
  logic       tout;
  logic       tclr;
  int         n_checks;
  int         n_errors;

  wb_pio_arbiter_if m0_if ();
  wb_pio_arbiter_if m1_if ();
  wb_pio_arbiter_if s_if ();

  wb_pio_arbiter #(.TIMEOUT(4), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .gnt_o         (gnt),
    .timeout_o     (tout),
    .timeout_clr_i (tclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
    m0_if.sel = 4'hF; m0_if.adr = adr; m0_if.dat_w = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
    m1_if.sel = 4'hF; m1_if.adr = adr; m1_if.dat_w = dat;
  endtask

  task automatic set_s(input logic ack, input logic [31:0] dat);
    s_if.ack = ack; s_if.dat_r = dat;
  endtask

  task automatic idle_inputs();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_s(1'b0, 32'h0);
    tclr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    rst_n = 1'b1;
    #1;
    check_eq("rst_gnt",  32'(gnt), 32'h0);
    check_eq("rst_tout", 32'(tout), 32'h0);
    check_eq("rst_scyc", 32'(s_if.cyc), 32'h0);
    check_eq("rst_m0dat", m0_if.dat_r, 32'h0);

    // Single m0 write, slave acks in cycle 3
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'h1234_5678);
    #3;
    check_eq("w_c0_gnt", 32'(gnt), 32'h0);
    check_eq("w_c0_sstb", 32'(s_if.stb), 32'h0);
    next_cycle(); #3;
    check_eq("w_c1_gnt", 32'(gnt), 32'h1);
    check_eq("w_c1_sstb", 32'(s_if.stb), 32'h1);
    check_eq("w_c1_sadr", s_if.adr, 32'h3000_0004);
    check_eq("w_c1_sdat", s_if.dat_w, 32'h1234_5678);
    check_eq("w_c1_swe", 32'(s_if.we), 32'h1);
    check_eq("w_c1_m0ack", 32'(m0_if.ack), 32'h0);
    next_cycle(); #3;
    check_eq("w_c2_m0ack", 32'(m0_if.ack), 32'h0);
    next_cycle();
    set_s(1'b1, 32'h0);
    #3;
    check_eq("w_c3_m0ack", 32'(m0_if.ack), 32'h1);
    check_eq("w_c3_m1ack", 32'(m1_if.ack), 32'h0);
    next_cycle();
    set_s(1'b0, 32'h0);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check_eq("w_c4_m0ack", 32'(m0_if.ack), 32'h0);
    check_eq("w_c4_scyc", 32'(s_if.cyc), 32'h0);
    check_eq("w_c4_gnt", 32'(gnt), 32'h1);
    next_cycle(); #3;
    check_eq("w_c5_gnt", 32'(gnt), 32'h0);

    // Tie after reset: m0 first, then m1 with no bubble, then alternation back to m0
    do_reset();
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_00A0, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0);
    #3;
    check_eq("tie_c0_gnt", 32'(gnt), 32'h0);
    next_cycle();
    set_s(1'b1, 32'h0000_00A0);
    #3;
    check_eq("tie_c1_gnt", 32'(gnt), 32'h1);
    check_eq("tie_c1_sadr", s_if.adr, 32'h0000_00A0);
    check_eq("tie_c1_m0ack", 32'(m0_if.ack), 32'h1);
    check_eq("tie_c1_m0dat", m0_if.dat_r, 32'h0000_00A0);
    check_eq("tie_c1_m1ack", 32'(m1_if.ack), 32'h0);
    check_eq("tie_c1_m1dat", m1_if.dat_r, 32'h0);
    next_cycle();
    set_s(1'b0, 32'h0);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check_eq("tie_c2_gnt", 32'(gnt), 32'h1);
    next_cycle();
    set_s(1'b1, 32'h1111_2222);
    #3;
    check_eq("tie_c3_gnt", 32'(gnt), 32'h2);
    check_eq("tie_c3_sadr", s_if.adr, 32'h0000_00B0);
    check_eq("tie_c3_m1ack", 32'(m1_if.ack), 32'h1);
    check_eq("tie_c3_m1dat", m1_if.dat_r, 32'h1111_2222);
    check_eq("tie_c3_m0ack", 32'(m0_if.ack), 32'h0);
    next_cycle();
    set_s(1'b0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_00A4, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_00B4, 32'h0);
    #3;
    check_eq("alt_c0_gnt", 32'(gnt), 32'h0);
    next_cycle();
    set_s(1'b1, 32'h0);
    #3;
    check_eq("alt_c1_gnt", 32'(gnt), 32'h1);
    next_cycle();
    set_s(1'b0, 32'h0);
    idle_inputs();
    #3;
    next_cycle(); #3;
    check_eq("alt_idle_gnt", 32'(gnt), 32'h0);

    // Lock: m1 (wins tie, last was m0) keeps cyc across 3 transfers while m0 waits
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_00C4, 32'h0);
    set_m1(1'b1, 1'b1, 1'b1, 32'h0000_00C0, 32'h5555_0000);
    #3;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      m1_if.stb = 1'b1;
      set_s(1'b1, 32'h0);
      #3;
      check_eq($sformatf("lock_%0d_gnt", k), 32'(gnt), 32'h2);
      check_eq($sformatf("lock_%0d_m1ack", k), 32'(m1_if.ack), 32'h1);
      check_eq($sformatf("lock_%0d_m0ack", k), 32'(m0_if.ack), 32'h0);
      next_cycle();
      m1_if.stb = 1'b0;
      set_s(1'b0, 32'h0);
      #3;
      check_eq($sformatf("lock_%0d_gap_gnt", k), 32'(gnt), 32'h2);
    end
    next_cycle();
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check_eq("lock_rel_gnt", 32'(gnt), 32'h2);
    next_cycle();
    set_s(1'b1, 32'h0);
    #3;
    check_eq("lock_m0_gnt", 32'(gnt), 32'h1);
    check_eq("lock_m0_ack", 32'(m0_if.ack), 32'h1);
    next_cycle();
    idle_inputs();
    #3;
    next_cycle(); #3;
    check_eq("lock_end_gnt", 32'(gnt), 32'h0);

    // Watchdog: slave never acks an m0 read
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    #3;
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); #3;
      check_eq($sformatf("to_c%0d_sstb", k), 32'(s_if.stb), 32'h1);
      check_eq($sformatf("to_c%0d_m0ack", k), 32'(m0_if.ack), 32'h0);
    end
    next_cycle(); #3;
    check_eq("to_c4_sstb", 32'(s_if.stb), 32'h0);
    check_eq("to_c4_scyc", 32'(s_if.cyc), 32'h0);
    check_eq("to_c4_m0ack", 32'(m0_if.ack), 32'h1);
    check_eq("to_c4_m0dat", m0_if.dat_r, 32'hDEAD_BEEF);
    check_eq("to_c4_tout", 32'(tout), 32'h0);
    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check_eq("to_c5_tout", 32'(tout), 32'h1);
    check_eq("to_c5_gnt", 32'(gnt), 32'h0);
    next_cycle();
    tclr = 1'b1;
    #3;
    check_eq("to_clr_hold", 32'(tout), 32'h1);
    next_cycle();
    tclr = 1'b0;
    #3;
    check_eq("to_clr_done", 32'(tout), 32'h0);

    // Real ack on the threshold cycle wins over the watchdog
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0014, 32'h0);
    #3;
    next_cycle(); #3;
    next_cycle(); #3;
    next_cycle(); #3;
    check_eq("ath_c3_m0ack", 32'(m0_if.ack), 32'h0);
    next_cycle();
    set_s(1'b1, 32'hA5A5_A5A5);
    #3;
    check_eq("ath_c4_sstb", 32'(s_if.stb), 32'h1);
    check_eq("ath_c4_m0ack", 32'(m0_if.ack), 32'h1);
    check_eq("ath_c4_m0dat", m0_if.dat_r, 32'hA5A5_A5A5);
    next_cycle();
    idle_inputs();
    #3;
    check_eq("ath_c5_tout", 32'(tout), 32'h0);
    next_cycle(); #3;
    check_eq("ath_c6_gnt", 32'(gnt), 32'h0);
    check_eq("ath_c6_tout", 32'(tout), 32'h0);

    // Async reset while m1 owns the bus with stb pending
    next_cycle();
    set_m1(1'b1, 1'b1, 1'b0, 32'h3000_0020, 32'h0);
    #3;
    next_cycle(); #3;
    check_eq("rm_pre_gnt", 32'(gnt), 32'h2);
    check_eq("rm_pre_scyc", 32'(s_if.cyc), 32'h1);
    set_s(1'b1, 32'h0000_0077);
    #1;
    check_eq("rm_pre_m1ack", 32'(m1_if.ack), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rm_scyc", 32'(s_if.cyc), 32'h0);
    check_eq("rm_sstb", 32'(s_if.stb), 32'h0);
    check_eq("rm_m1ack", 32'(m1_if.ack), 32'h0);
    check_eq("rm_gnt", 32'(gnt), 32'h0);
    idle_inputs();
    #2;
    rst_n = 1'b1;
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_00D0, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_00D4, 32'h0);
    #3;
    check_eq("rm_tie_c0_gnt", 32'(gnt), 32'h0);
    next_cycle(); #3;
    check_eq("rm_tie_c1_gnt", 32'(gnt), 32'h1);
    next_cycle();
    idle_inputs();
    #3;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
